// File: rtl/keypad_pkg.sv
// Shared constants, widths and state encoding for the keypad entry front-end.
package keypad_pkg;

  localparam int unsigned KEY_W   = 4;
  localparam int unsigned ACC_W   = 7;
  localparam int unsigned PASS_W  = 4;
  localparam int unsigned VALUE_W = 5;
  localparam int unsigned COUNT_W = 2;

  localparam logic [KEY_W-1:0] KEY_CLR   = 4'd10;
  localparam logic [KEY_W-1:0] KEY_ENTER = 4'd11;

  localparam logic [ACC_W-1:0] PASS_LIMIT  = 7'd15;
  localparam logic [ACC_W-1:0] VALUE_LIMIT = 7'd31;
  localparam logic [ACC_W-1:0] ACC_MAX     = 7'd127;

  // One-hot entry states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_ENTRY  = 3'b010,
    ST_SUBMIT = 3'b100
  } state_t;

  // True for decimal digit key codes 0..9
  function automatic logic is_digit(input logic [KEY_W-1:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_timer.sv
// Reloadable inactivity down-counter; expire is a registered one-cycle pulse
// that lands in the cycle where the owner has been idle TIMEOUT_CYCLES-1 edges.
module keypad_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic Clock,
  input  logic Clear,
  input  logic reload,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count down while enabled; raise expire one edge early so the owner sees it on the last idle edge
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (reload) begin
        cnt <= RELOAD_VAL;
      end else if (enable) begin
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) expire <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry front-end: assembles decimal keystrokes into Password/Value words.
// Optional inactivity timeout is enabled by defining KEYPAD_TIMEOUT_EN.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_DIGITS     = 2
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               Working,
  input  logic               PassMode,
  input  logic               KeyValid,
  input  logic [KEY_W-1:0]   KeyCode,
  output logic [PASS_W-1:0]  Password,
  output logic [VALUE_W-1:0] Value,
  output logic               Submit,
  output logic               ErrEntry,
  output logic               Timeout,
  output logic [COUNT_W-1:0] DigitCount
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic             key_accept_c;
  logic [10:0]      acc_mac_c;
  logic [ACC_W-1:0] acc_next_c;
  logic [ACC_W-1:0] limit_c;
  logic             timer_expire;

  // Key qualification, next accumulator value (saturating) and active limit
  always_comb begin
    key_accept_c = KeyValid && (KeyCode <= KEY_ENTER) && (state != ST_SUBMIT);
    acc_mac_c    = 11'(acc) * 11'd10 + 11'(KeyCode);
    acc_next_c   = (acc_mac_c > 11'(ACC_MAX)) ? ACC_MAX : acc_mac_c[ACC_W-1:0];
    limit_c      = PassMode ? PASS_LIMIT : VALUE_LIMIT;
  end

`ifdef KEYPAD_TIMEOUT_EN
  logic timer_reload_c;

  // Every accepted key restarts the inactivity window
  always_comb timer_reload_c = Working && key_accept_c;

  keypad_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .Clock  (Clock),
    .Clear  (Clear),
    .reload (timer_reload_c),
    .enable (state == ST_ENTRY),
    .expire (timer_expire)
  );
`else
  logic unused_timeout_cfg;

  assign timer_expire       = 1'b0;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYCLES);
`endif

  // Entry FSM with registered pulses and result words
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state      <= ST_IDLE;
      acc        <= '0;
      DigitCount <= '0;
      Password   <= '0;
      Value      <= '0;
      Submit     <= 1'b0;
      ErrEntry   <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      Submit   <= 1'b0;
      ErrEntry <= 1'b0;
      Timeout  <= 1'b0;
      if (!Working) begin
        state      <= ST_IDLE;
        acc        <= '0;
        DigitCount <= '0;
      end else begin
        unique case (state)
          ST_IDLE, ST_ENTRY: begin
            if (key_accept_c) begin
              if (is_digit(KeyCode)) begin
                if (32'(DigitCount) < MAX_DIGITS) begin
                  acc        <= acc_next_c;
                  DigitCount <= DigitCount + COUNT_W'(1);
                  state      <= ST_ENTRY;
                end else begin
                  ErrEntry   <= 1'b1;
                  acc        <= '0;
                  DigitCount <= '0;
                  state      <= ST_IDLE;
                end
              end else if (KeyCode == KEY_CLR) begin
                acc        <= '0;
                DigitCount <= '0;
                state      <= ST_IDLE;
              end else begin
                if (state == ST_IDLE) begin
                  ErrEntry <= 1'b1;
                  state    <= ST_IDLE;
                end else if (acc <= limit_c) begin
                  if (PassMode) Password <= acc[PASS_W-1:0];
                  else          Value    <= acc[VALUE_W-1:0];
                  Submit <= 1'b1;
                  state  <= ST_SUBMIT;
                end else begin
                  ErrEntry <= 1'b1;
                  state    <= ST_IDLE;
                end
                acc        <= '0;
                DigitCount <= '0;
              end
            end else if ((state == ST_ENTRY) && timer_expire) begin
              Timeout    <= 1'b1;
              acc        <= '0;
              DigitCount <= '0;
              state      <= ST_IDLE;
            end
          end
          ST_SUBMIT: state <= ST_IDLE;
          default: begin
            acc        <= '0;
            DigitCount <= '0;
            state      <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus random keystrokes
// compared each cycle against a decimal-arithmetic reference model.
module tb_keypad_entry;

  localparam int unsigned T_CYC = 8;
  localparam int unsigned MAXD  = 2;

  logic       Clock = 1'b0;
  logic       Clear;
  logic       Working;
  logic       PassMode;
  logic       KeyValid;
  logic [3:0] KeyCode;
  logic [3:0] Password;
  logic [4:0] Value;
  logic       Submit;
  logic       ErrEntry;
  logic       Timeout;
  logic [1:0] DigitCount;

  int total = 0;
  int bad   = 0;

  // Reference model state: digits held, decimal value, idle edges, submit cycle
  int m_n, m_v, m_idle, m_pass, m_val;
  bit m_sub, e_sub, e_err, e_tmo;
  bit cur_pm;

  keypad_entry #(
    .TIMEOUT_CYCLES(T_CYC),
    .MAX_DIGITS    (MAXD)
  ) dut (
    .Clock      (Clock),
    .Clear      (Clear),
    .Working    (Working),
    .PassMode   (PassMode),
    .KeyValid   (KeyValid),
    .KeyCode    (KeyCode),
    .Password   (Password),
    .Value      (Value),
    .Submit     (Submit),
    .ErrEntry   (ErrEntry),
    .Timeout    (Timeout),
    .DigitCount (DigitCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_v = 0; m_idle = 0; m_pass = 0; m_val = 0;
    m_sub = 0; e_sub = 0; e_err = 0; e_tmo = 0;
  endtask

  // One clock edge of the reference behaviour
  task automatic model_step(input bit w, input bit pm, input bit kv, input int code);
    int lim;
    e_sub = 0; e_err = 0; e_tmo = 0;
    if (!w) begin
      m_n = 0; m_v = 0; m_idle = 0; m_sub = 0;
    end else if (m_sub) begin
      m_sub = 0;
    end else if (kv && code <= 11) begin
      m_idle = 0;
      if (code <= 9) begin
        if (m_n < int'(MAXD)) begin
          m_v = m_v * 10 + code;
          m_n++;
        end else begin
          e_err = 1; m_n = 0; m_v = 0;
        end
      end else if (code == 10) begin
        m_n = 0; m_v = 0;
      end else begin
        if (m_n == 0) begin
          e_err = 1;
        end else begin
          lim = pm ? 15 : 31;
          if (m_v <= lim) begin
            if (pm) m_pass = m_v;
            else    m_val  = m_v;
            e_sub = 1; m_sub = 1;
          end else begin
            e_err = 1;
          end
          m_n = 0; m_v = 0;
        end
      end
    end else if (m_n > 0) begin
`ifdef KEYPAD_TIMEOUT_EN
      m_idle++;
      if (m_idle == int'(T_CYC)) begin
        e_tmo = 1; m_n = 0; m_v = 0; m_idle = 0;
      end
`endif
    end
  endtask

  task automatic check_all();
    chk("submit",      32'(Submit),     32'(e_sub));
    chk("err_entry",   32'(ErrEntry),   32'(e_err));
    chk("timeout",     32'(Timeout),    32'(e_tmo));
    chk("digit_count", 32'(DigitCount), 32'(m_n));
    chk("password",    32'(Password),   32'(m_pass));
    chk("value",       32'(Value),      32'(m_val));
  endtask

  task automatic cycle(input bit w, input bit pm, input bit kv, input logic [3:0] code);
    @(negedge Clock);
    Working = w; PassMode = pm; KeyValid = kv; KeyCode = code;
    @(posedge Clock);
    model_step(w, pm, kv, int'(code));
    #1;
    check_all();
  endtask

  task automatic key(input logic [3:0] code);
    cycle(1'b1, cur_pm, 1'b1, code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, cur_pm, 1'b0, 4'd0);
  endtask

  initial begin
    int seen;
    int exp_seen;
    int r;
    bit kv;
    logic [3:0] code;

    Clear = 1'b1; Working = 1'b1; PassMode = 1'b0; KeyValid = 1'b0; KeyCode = 4'd0;
    cur_pm = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge Clock);
    Clear = 1'b0;

    // Password 12
    cur_pm = 1'b1;
    key(4'd1); key(4'd2); key(4'd11);
    chk("pw12_password", 32'(Password), 32'd12);
    chk("pw12_submit",   32'(Submit),   32'd1);
    idle(1);

    // Value overflow then value 31
    cur_pm = 1'b0;
    key(4'd3); key(4'd2); key(4'd11);
    chk("val32_err", 32'(ErrEntry), 32'd1);
    key(4'd3); key(4'd1); key(4'd11);
    chk("val31_value", 32'(Value), 32'd31);
    key(4'd5);   // dropped during SUBMIT
    key(4'd5);   // earliest accepted key
    key(4'd10);

    // Too many digits, ENTER with nothing, CLR mid-entry
    key(4'd1); key(4'd2); key(4'd3);
    key(4'd11);
    cur_pm = 1'b1;
    key(4'd5); key(4'd10); key(4'd7); key(4'd11);
    chk("pw7_password", 32'(Password), 32'd7);
    idle(1);

    // Ignored codes inside an entry
    key(4'd2); key(4'd13); key(4'd15); key(4'd11);
    idle(1);

    // Digit followed by silence
    key(4'd4);
    seen = 0;
    for (int i = 1; i <= 100; i++) begin
      idle(1);
      if (Timeout === 1'b1 && seen == 0) seen = i + 1;
    end
`ifdef KEYPAD_TIMEOUT_EN
    exp_seen = int'(T_CYC) + 1;
`else
    exp_seen = 0;
`endif
    chk("timeout_cycle", 32'(seen), 32'(exp_seen));
    key(4'd10);

    // Working low overrides a key and drops the entry
    key(4'd9);
    cycle(1'b0, cur_pm, 1'b1, 4'd11);
    chk("working_low_count", 32'(DigitCount), 32'd0);
    idle(2);

    // Asynchronous Clear while Submit is high
    key(4'd1); key(4'd11);
    chk("pre_clear_submit", 32'(Submit), 32'd1);
    #2;
    Clear = 1'b1;
    #1;
    chk("clr_submit",   32'(Submit),     32'd0);
    chk("clr_password", 32'(Password),   32'd0);
    chk("clr_value",    32'(Value),      32'd0);
    chk("clr_err",      32'(ErrEntry),   32'd0);
    chk("clr_timeout",  32'(Timeout),    32'd0);
    chk("clr_count",    32'(DigitCount), 32'd0);
    model_reset();
    @(negedge Clock);
    Clear = 1'b0;

    // Random keystroke traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        idle(int'($urandom_range(6, 12)));
      end else begin
        cur_pm = 1'($urandom_range(0, 1));
        kv     = ($urandom_range(0, 99) < 45);
        r      = int'($urandom_range(0, 99));
        code   = (r < 70) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
        cycle(($urandom_range(0, 99) >= 3), cur_pm, kv, code);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Upstream front-end for the ATM controller. It collects decimal keystrokes from the keypad scanner and assembles them into the 4-bit `Password` or 5-bit `Value` word the controller consumes. On ENTER it issues a one-cycle `Submit`. It also flags malformed or overflowing entries, and abandons stale entries after an inactivity timeout.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000: idle cycles inside an entry before it is abandoned; legal range 2..65535.
- `MAX_DIGITS`, default 2: maximum digits per entry.

Ports:
- `Clock`  in  1  module clock; all state changes on the rising edge.
- `Clear`  in  1  asynchronous, active-high reset.
- `Working`  in  1  controller Working LED. While low, the block is held idle and keys are ignored.
- `PassMode`  in  1  1 = assembling a password (limit 15); 0 = assembling a withdraw value (limit 31). Sampled at ENTER.
- `KeyValid`  in  1  one-cycle strobe from the keypad scanner.
- `KeyCode`  in  4  0–9 digit, 10 CLR (clear entry), 11 ENTER, 12–15 ignored.
- `Password`  out  4  last submitted password.
- `Value`  out  5  last submitted value.
- `Submit`  out  1  one-cycle pulse; `Password`/`Value` are valid while it is high.
- `ErrEntry`  out  1  one-cycle pulse: overflow, too many digits, or ENTER with no digits.
- `Timeout`  out  1  one-cycle pulse: entry abandoned for inactivity.
- `DigitCount`  out  2  digits currently held, for the display.

## Operation
- States:
  - IDLE: no digits held.
  - ENTRY: 1..MAX_DIGITS digits held.
  - SUBMIT: `Submit` high.
  - Encoding is one-hot.
- Accumulator `acc` is 7 bits.
  - A digit key with count < MAX_DIGITS sets acc ← acc*10 + d, increments count, and moves IDLE→ENTRY.
  - A digit key with count = MAX_DIGITS pulses `ErrEntry`, clears acc/count and returns to IDLE.
- CLR: clears acc/count, returns to IDLE, no error.
- ENTER handling:
  - In IDLE: pulses `ErrEntry` and stays in IDLE.
  - In ENTRY, limit = PassMode ? 15 : 31.
  - If acc ≤ limit: load `Password` (PassMode=1) or `Value` (PassMode=0) from acc; the other output is unchanged. Clear acc/count and go to SUBMIT.
  - If acc > limit: pulse `ErrEntry`, clear, go to IDLE.
- SUBMIT → IDLE unconditionally after one cycle. Any key arriving in SUBMIT is dropped.
- Keys 12–15 are ignored and do not restart the inactivity timer.
- `Working` low: acc/count cleared, state forced to IDLE, no pulses generated. `Password`/`Value` are retained.
- Simultaneous events:
  - `Working` low overrides any key.
  - Timeout expiry and a key in the same cycle: the key wins and the timer restarts.

## Timing
- Reset values: state IDLE; `Password`=0, `Value`=0, `Submit`=0, `ErrEntry`=0, `Timeout`=0, `DigitCount`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- ENTER sampled at edge N: `Submit`, `Password`/`Value` update at edge N (visible in cycle N+1). `Submit` is high for exactly one cycle and low from edge N+1.
- `ErrEntry`/`Timeout` appear one cycle after the offending key or expiry, for one cycle.
- Back-to-back entries: the earliest next accepted key is at edge N+2.
- Inactivity timer:
  - Counts only in ENTRY and reloads on each accepted key.
  - At count = TIMEOUT_CYCLES−1 it pulses `Timeout`, clears acc/count and returns to IDLE.
  - A digit followed by silence gives `Timeout` high in cycle TIMEOUT_CYCLES+1 after the digit edge.
- `Clear` asserted mid-entry: all state and outputs return to reset values immediately (asynchronously), including a `Submit` in progress.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined: the inactivity timer and `Timeout` behaviour are present as described.
- Undefined: no timer logic. `Timeout` is tied to 0 and an entry persists indefinitely until ENTER, CLR, `Working` low or `Clear`.

## Structure
- Shared package `keypad_pkg` holds:
  - key code constants `KEY_CLR`=10 and `KEY_ENTER`=11;
  - limits `PASS_LIMIT`=15 and `VALUE_LIMIT`=31;
  - state encodings for IDLE/ENTRY/SUBMIT.
- One sub-module, `keypad_timer`: a reloadable down-counter with `reload`, `enable` and `expire` signals, instantiated only under `KEYPAD_TIMEOUT_EN`.

## Test plan
- PassMode=1, keys 1, 2, ENTER → `Password`=12, `Submit` high for one cycle, `Value` unchanged at 0.
- PassMode=0, keys 3, 2, ENTER → `ErrEntry` pulse (32 > 31), no `Submit`, `DigitCount`=0. Then keys 3, 1, ENTER → `Value`=31, `Submit` pulse.
- Keys 1, 2, 3 → `ErrEntry` on the third digit. ENTER in IDLE → `ErrEntry`. Keys 5, CLR, 7, ENTER (PassMode=1) → `Password`=7.
- With `KEYPAD_TIMEOUT_EN` and TIMEOUT_CYCLES=8: key 4 then silence → `Timeout` pulse 9 cycles later, `DigitCount` back to 0. Without the macro, no pulse after 100 cycles.
- Key 9 then `Working` low → `DigitCount`=0, no pulses. `Clear` asserted mid-cycle during SUBMIT → `Submit` drops immediately and all outputs read 0.
